// File: rtl/result_drain_unit.sv
// Streams the result matrix out of cache memory in row-major order, one
// element per read, then appends the six latched cache counters and pulses done.
module result_drain_unit #(
  parameter int BYTE_SIZE = 8,
  parameter int NUM_ROWS  = 64,
  parameter int NUM_COLS  = 64,
  parameter int IDX_W     = 6,
  parameter int ADDR_W    = 12,
  parameter int STAT_W    = 19
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic                 mem_rd_req,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  input  logic                 mem_rd_valid,
  input  logic [BYTE_SIZE-1:0] mem_rd_data,
  input  logic [15:0]          num_of_read_hit,
  input  logic [15:0]          num_of_read_miss,
  input  logic [15:0]          num_of_write_hit,
  input  logic [15:0]          num_of_write_miss,
  input  logic [STAT_W-1:0]    read_hit_cycle,
  input  logic [STAT_W-1:0]    write_hit_cycle,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [STAT_W-1:0]    out_data,
  output logic [IDX_W-1:0]     out_row,
  output logic [IDX_W-1:0]     out_col,
  output logic                 out_eol,
  output logic                 out_is_stat,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           dbg_state
);

  // Stream handshake: a word transfers on a rising edge where out_valid and
  // out_ready are both high; out_valid and every out_* field come straight
  // from registers and hold until that edge, independent of out_ready.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_STAT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NUM_ROWS - 1);
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(NUM_COLS - 1);

  state_t              state_q;
  logic [IDX_W-1:0]    row_q, col_q;
  logic [IDX_W-1:0]    row_d, col_d;
  logic [2:0]          stat_idx_q;
  logic [15:0]         rd_hit_q, rd_miss_q, wr_hit_q, wr_miss_q;
  logic [STAT_W-1:0]   rd_hit_cyc_q, wr_hit_cyc_q;
  logic                req_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                valid_q;
  logic [STAT_W-1:0]   data_q;
  logic                eol_q, is_stat_q, last_q, busy_q, done_q;
  logic                last_col, last_row, hs;

  always_comb begin
    last_col = (col_q == LAST_COL);
    last_row = (row_q == LAST_ROW);
    col_d    = last_col ? '0 : col_q + 1'b1;
    row_d    = last_col ? row_q + 1'b1 : row_q;
    hs       = valid_q && out_ready;
  end

  // Statistics record order on the stream.
  function automatic logic [STAT_W-1:0] stat_sel(input logic [2:0] idx);
    case (idx)
      3'd0:    stat_sel = STAT_W'(rd_hit_q);
      3'd1:    stat_sel = rd_hit_cyc_q;
      3'd2:    stat_sel = STAT_W'(rd_miss_q);
      3'd3:    stat_sel = STAT_W'(wr_hit_q);
      3'd4:    stat_sel = wr_hit_cyc_q;
      3'd5:    stat_sel = STAT_W'(wr_miss_q);
      default: stat_sel = '0;
    endcase
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      stat_idx_q   <= '0;
      rd_hit_q     <= '0;
      rd_miss_q    <= '0;
      wr_hit_q     <= '0;
      wr_miss_q    <= '0;
      rd_hit_cyc_q <= '0;
      wr_hit_cyc_q <= '0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      eol_q        <= 1'b0;
      is_stat_q    <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      req_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q       <= base_addr;
            rd_hit_q     <= num_of_read_hit;
            rd_miss_q    <= num_of_read_miss;
            wr_hit_q     <= num_of_write_hit;
            wr_miss_q    <= num_of_write_miss;
            rd_hit_cyc_q <= read_hit_cycle;
            wr_hit_cyc_q <= write_hit_cycle;
            row_q        <= '0;
            col_q        <= '0;
            busy_q       <= 1'b1;
            req_q        <= 1'b1;
            state_q      <= S_REQ;
          end
        end
        S_REQ: state_q <= S_WAIT;
        S_WAIT: begin
          if (mem_rd_valid) begin
            data_q  <= STAT_W'(mem_rd_data);
            eol_q   <= last_col;
            valid_q <= 1'b1;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (hs) begin
            eol_q <= 1'b0;
            if (last_row && last_col) begin
              row_q      <= '0;
              col_q      <= '0;
              stat_idx_q <= 3'd0;
              is_stat_q  <= 1'b1;
              data_q     <= stat_sel(3'd0);
              state_q    <= S_STAT;
            end else begin
              // Row-major layout means the next element is simply the next word.
              row_q   <= row_d;
              col_q   <= col_d;
              addr_q  <= addr_q + 1'b1;
              valid_q <= 1'b0;
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end
          end
        end
        S_STAT: begin
          if (hs) begin
            if (stat_idx_q == 3'd5) begin
              valid_q   <= 1'b0;
              is_stat_q <= 1'b0;
              last_q    <= 1'b0;
              data_q    <= '0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              stat_idx_q <= stat_idx_q + 3'd1;
              data_q     <= stat_sel(stat_idx_q + 3'd1);
              last_q     <= (stat_idx_q == 3'd4);
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_rd_req  = req_q;
  assign mem_rd_addr = addr_q;
  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_row     = row_q;
  assign out_col     = col_q;
  assign out_eol     = eol_q;
  assign out_is_stat = is_stat_q;
  assign out_last    = last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_result_drain_unit.sv
// Bench for result_drain_unit: a 2x3 instance for the focused scenarios and a
// default 64x64 instance for the full drain, sharing one memory model and monitor.
module tb_result_drain_unit;

  localparam int STAT_W = 19;
  localparam int IDX_W  = 6;
  localparam int ADDR_W = 12;
  localparam int W      = STAT_W + 2 * IDX_W + 3;
  localparam int SR     = 2;
  localparam int SC     = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic clk_run;
  logic rst;

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  // ---------------- shared stimulus ----------------
  logic              start_b, start_s;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_rd_valid;
  logic [7:0]        mem_rd_data;
  logic [15:0]       rh, rm, wh, wm;
  logic [STAT_W-1:0] rhc, whc;
  logic              out_ready = 1'b1;
  logic              sel_big;

  // ---------------- DUT outputs ----------------
  logic b_req, b_valid, b_eol, b_stat, b_last, b_busy, b_done;
  logic s_req, s_valid, s_eol, s_stat, s_last, s_busy, s_done;
  logic [ADDR_W-1:0] b_addr, s_addr;
  logic [STAT_W-1:0] b_data, s_data;
  logic [IDX_W-1:0]  b_row, b_col, s_row, s_col;
  logic [2:0]        b_dbg, s_dbg;

  result_drain_unit u_big (
    .CLK(clk), .RST(rst), .start(start_b), .base_addr(base_addr),
    .mem_rd_req(b_req), .mem_rd_addr(b_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .num_of_read_hit(rh), .num_of_read_miss(rm),
    .num_of_write_hit(wh), .num_of_write_miss(wm),
    .read_hit_cycle(rhc), .write_hit_cycle(whc),
    .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data),
    .out_row(b_row), .out_col(b_col), .out_eol(b_eol),
    .out_is_stat(b_stat), .out_last(b_last),
    .busy(b_busy), .done(b_done), .dbg_state(b_dbg)
  );

  result_drain_unit #(.NUM_ROWS(SR), .NUM_COLS(SC)) u_small (
    .CLK(clk), .RST(rst), .start(start_s), .base_addr(base_addr),
    .mem_rd_req(s_req), .mem_rd_addr(s_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .num_of_read_hit(rh), .num_of_read_miss(rm),
    .num_of_write_hit(wh), .num_of_write_miss(wm),
    .read_hit_cycle(rhc), .write_hit_cycle(whc),
    .out_valid(s_valid), .out_ready(out_ready), .out_data(s_data),
    .out_row(s_row), .out_col(s_col), .out_eol(s_eol),
    .out_is_stat(s_stat), .out_last(s_last),
    .busy(s_busy), .done(s_done), .dbg_state(s_dbg)
  );

  logic              m_req, m_valid, m_eol, m_stat, m_last, m_busy, m_done;
  logic [ADDR_W-1:0] m_addr;
  logic [STAT_W-1:0] m_data;
  logic [IDX_W-1:0]  m_row, m_col;
  logic [W-1:0]      cur_word;
  logic [49:0]       b_all, s_all;

  assign m_req   = sel_big ? b_req   : s_req;
  assign m_addr  = sel_big ? b_addr  : s_addr;
  assign m_valid = sel_big ? b_valid : s_valid;
  assign m_data  = sel_big ? b_data  : s_data;
  assign m_row   = sel_big ? b_row   : s_row;
  assign m_col   = sel_big ? b_col   : s_col;
  assign m_eol   = sel_big ? b_eol   : s_eol;
  assign m_stat  = sel_big ? b_stat  : s_stat;
  assign m_last  = sel_big ? b_last  : s_last;
  assign m_busy  = sel_big ? b_busy  : s_busy;
  assign m_done  = sel_big ? b_done  : s_done;
  assign cur_word = {m_stat, m_last, m_eol, m_row, m_col, m_data};
  assign b_all = {b_req, b_addr, b_valid, b_data, b_row, b_col, b_eol, b_stat, b_last, b_busy, b_done};
  assign s_all = {s_req, s_addr, s_valid, s_data, s_row, s_col, s_eol, s_stat, s_last, s_busy, s_done};

  // ---------------- scoreboard state ----------------
  logic [W-1:0]      exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int pop_idx  = 0;
  int stall_n  = 0;
  int rdy_mode = 0;
  logic tog = 1'b0;
  logic stall_prev = 1'b0;
  logic [W-1:0] held_word;
  logic pend = 1'b0;
  int unsigned pend_cnt = 0;
  logic [ADDR_W-1:0] pend_addr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model: data = addr + 10 ----------------
  always @(posedge clk) begin
    #1;
    mem_rd_valid = 1'b0;
    if (rst) pend = 1'b0;
    else if (pend) begin
      if (pend_cnt == 0) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = pend_addr[7:0] + 8'd10;
        pend = 1'b0;
      end else pend_cnt--;
    end
  end

  // ---------------- consumer ready driver ----------------
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (m_valid && !m_stat && pop_idx == 1 && stall_n < 5) begin
      out_ready = 1'b0;
      stall_n++;
    end else if (m_valid && m_stat) begin
      out_ready = tog;
      tog = ~tog;
    end else out_ready = 1'b1;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0]      e;
    logic [ADDR_W-1:0] ea;
    if (rst) stall_prev = 1'b0;
    else begin
      if (stall_prev) begin
        check_eq("hold_valid", 64'(m_valid), 64'd1);
        check_eq("hold_word", 64'(cur_word), 64'(held_word));
      end
      if (m_valid && out_ready) begin
        check_eq("word_avail", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq($sformatf("word%0d", pop_idx), 64'(cur_word), 64'(e));
        end
        pop_idx++;
      end
      stall_prev = m_valid && !out_ready;
      held_word  = cur_word;
      if (m_req) begin
        check_eq("req_avail", 64'(exp_addr_q.size() != 0), 64'd1);
        if (exp_addr_q.size() != 0) begin
          ea = exp_addr_q.pop_front();
          check_eq("rd_addr", 64'(m_addr), 64'(ea));
        end
        pend_addr = m_addr;
        pend_cnt  = $urandom_range(0, 2);
        pend      = 1'b1;
      end
      if (m_done) begin
        done_cnt++;
        check_eq("busy_at_done", 64'(m_busy), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic randomize_inputs();
    rh  = 16'($urandom);
    rm  = 16'($urandom);
    wh  = 16'($urandom);
    wm  = 16'($urandom);
    rhc = STAT_W'($urandom);
    whc = STAT_W'($urandom);
  endtask

  task automatic push_expect(input logic big, input logic [ADDR_W-1:0] base);
    int nr;
    int nc;
    logic [ADDR_W-1:0] a;
    logic [7:0] d;
    nr = big ? 64 : SR;
    nc = big ? 64 : SC;
    for (int i = 0; i < nr * nc; i++) begin
      a = base + ADDR_W'(i);
      d = a[7:0] + 8'd10;
      exp_addr_q.push_back(a);
      exp_q.push_back({1'b0, 1'b0, 1'((i % nc) == nc - 1), IDX_W'(i / nc), IDX_W'(i % nc), STAT_W'(d)});
    end
    exp_q.push_back({3'b100, 12'd0, STAT_W'(rh)});
    exp_q.push_back({3'b100, 12'd0, rhc});
    exp_q.push_back({3'b100, 12'd0, STAT_W'(rm)});
    exp_q.push_back({3'b100, 12'd0, STAT_W'(wh)});
    exp_q.push_back({3'b100, 12'd0, whc});
    exp_q.push_back({3'b110, 12'd0, STAT_W'(wm)});
  endtask

  task automatic pulse_start(input logic big);
    @(posedge clk); #1;
    if (big) start_b = 1'b1; else start_s = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", 64'(done_cnt != d0), 64'd1);
    repeat (3) @(negedge clk);
    check_eq("done_pulses", 64'(done_cnt - d0), 64'd1);
    check_eq("busy_after", 64'(m_busy), 64'd0);
    check_eq("words_left", 64'(exp_q.size()), 64'd0);
    check_eq("reqs_left", 64'(exp_addr_q.size()), 64'd0);
  endtask

  task automatic run_drain(input logic big, input logic [ADDR_W-1:0] base, input bit extra_start);
    sel_big   = big;
    base_addr = base;
    randomize_inputs();
    push_expect(big, base);
    pop_idx = 0;
    pulse_start(big);
    // Inputs move after acceptance; the drain must keep the latched values.
    randomize_inputs();
    base_addr = ADDR_W'($urandom);
    if (extra_start) begin
      repeat (3) @(posedge clk);
      pulse_start(big);
    end
    wait_done(big ? 40000 : 600);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int d0;
    clk_run = 1'b1;
    rst = 1'b1;
    start_b = 1'b0;
    start_s = 1'b0;
    sel_big = 1'b0;
    base_addr = '0;
    mem_rd_valid = 1'b0;
    mem_rd_data = '0;
    randomize_inputs();
    repeat (3) @(negedge clk);
    check_eq("reset_out_big", 64'(b_all), 64'd0);
    check_eq("reset_out_small", 64'(s_all), 64'd0);
    check_eq("reset_state", 64'(s_dbg), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    run_drain(1'b0, 12'd0, 1'b0);

    rdy_mode = 1;
    stall_n = 0;
    tog = 1'b0;
    run_drain(1'b0, 12'd100, 1'b0);
    rdy_mode = 0;
    check_eq("bp_stalls", 64'(stall_n), 64'd5);

    run_drain(1'b0, 12'd4094, 1'b0);
    run_drain(1'b0, 12'd200, 1'b1);

    // Reset while waiting on memory: outputs clear, no done pulse.
    sel_big = 1'b0;
    base_addr = 12'd500;
    push_expect(1'b0, 12'd500);
    pop_idx = 0;
    pulse_start(1'b0);
    n = 0;
    while (s_dbg != 3'd2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_wait", 64'(s_dbg), 64'd2);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check_eq("rst_wait_out", 64'(s_all), 64'd0);
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("no_done_on_rst", 64'(done_cnt), 64'(d0));
    check_eq("idle_after_rst", 64'(s_dbg), 64'd0);
    run_drain(1'b0, 12'd777, 1'b0);

    // Reset with the clock stopped while a word is being presented.
    base_addr = 12'd40;
    push_expect(1'b0, 12'd40);
    pop_idx = 0;
    pulse_start(1'b0);
    n = 0;
    while (!s_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_send", 64'(s_valid), 64'd1);
    @(negedge clk);
    clk_run = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_eq("async_rst_out", 64'(s_all), 64'd0);
    #2 rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    #2 clk_run = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("async_rst_state", 64'(s_dbg), 64'd0);
    check_eq("async_rst_idle_out", 64'(s_all), 64'd0);

    run_drain(1'b1, 12'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
